// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - mode encoding, widths and extension function for imm_ext_pipe
package imm_ext_pkg;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'b00,
      EXT_ZERO   = 2'b01,
      EXT_UPPER  = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_mode_t;

   localparam int STAT_W    = 16;
   localparam int EXT_MAX_W = 64;

   // Widths arrive as elaboration constants; the caller truncates the result to out_w bits.
   function automatic logic [EXT_MAX_W-1:0] ext_compute(
      input logic [EXT_MAX_W-1:0] imm,
      input ext_mode_t            mode,
      input int                   in_w,
      input int                   out_w
   );
      logic [EXT_MAX_W-1:0] low_mask;
      logic [EXT_MAX_W-1:0] zext;
      logic [EXT_MAX_W-1:0] sext;
      logic [EXT_MAX_W-1:0] res;
      low_mask = ~({EXT_MAX_W{1'b1}} << in_w);
      zext     = imm & low_mask;
      sext     = zext;
      if (((zext >> (in_w - 1)) & {{(EXT_MAX_W-1){1'b0}}, 1'b1}) != '0) begin
         sext = zext | ~low_mask;
      end
      case (mode)
         EXT_SIGN:   res = sext;
         EXT_ZERO:   res = zext;
         EXT_UPPER:  res = zext << (out_w - in_w);
         EXT_BRANCH: res = sext << 2;
         default:    res = sext;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/imm_ext_skid.sv
// rtl/imm_ext_skid.sv - 2-entry valid/ready skid buffer with registered in_ready
module imm_ext_skid #(
   parameter int W = 36
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         or_valid, or_valid_nx;
   logic         sk_valid, sk_valid_nx;
   logic [W-1:0] or_data, or_data_nx;
   logic [W-1:0] sk_data, sk_data_nx;
   logic         rdy;
   logic         accept;
   logic         drain;

   assign accept    = in_valid && rdy;
   assign drain     = or_valid && out_ready;
   assign in_ready  = rdy;
   assign out_valid = or_valid;
   assign out_data  = or_data;

   // rdy mirrors !sk_valid, so an accept never coincides with a full skid slot.
   always_comb begin
      or_valid_nx = or_valid;
      or_data_nx  = or_data;
      sk_valid_nx = sk_valid;
      sk_data_nx  = sk_data;
      if (drain && sk_valid) begin
         or_data_nx  = sk_data;
         sk_valid_nx = 1'b0;
      end else if (drain || !or_valid) begin
         or_valid_nx = accept;
         if (accept) begin
            or_data_nx = in_data;
         end
      end else if (accept) begin
         sk_valid_nx = 1'b1;
         sk_data_nx  = in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         or_valid <= 1'b0;
         or_data  <= '0;
         sk_valid <= 1'b0;
         sk_data  <= '0;
         rdy      <= 1'b0;
      end else begin
         or_valid <= or_valid_nx;
         or_data  <= or_data_nx;
         sk_valid <= sk_valid_nx;
         sk_data  <= sk_data_nx;
         rdy      <= !sk_valid_nx;
      end
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate extender; IMM_EXT_STATS_EN adds per-mode accept counters
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  ext_mode_t        in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_STATS_EN
   ,
   input  logic [1:0]        stat_sel,
   output logic [STAT_W-1:0] stat_count
`endif
);

   if ((IN_W < 2) || (OUT_W < IN_W + 2) || (OUT_W > EXT_MAX_W)) begin : g_param_check
      $error("imm_ext_pipe: illegal IN_W/OUT_W combination");
   end

   logic [OUT_W-1:0] ext_data;

   assign ext_data = OUT_W'(ext_compute(EXT_MAX_W'(in_imm), in_mode, IN_W, OUT_W));

   imm_ext_skid #(
      .W (OUT_W + TAG_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({ext_data, in_tag}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({out_data, out_tag})
   );

`ifdef IMM_EXT_STATS_EN
   logic [STAT_W-1:0] stat_cnt [4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            stat_cnt[i] <= '0;
         end
      end else if (in_valid && in_ready && (stat_cnt[in_mode] != {STAT_W{1'b1}})) begin
         stat_cnt[in_mode] <= stat_cnt[in_mode] + STAT_W'(1);
      end
   end

   assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - directed self-checking bench; IMM_EXT_STATS_EN selects the 8->16 stats build
module tb_imm_ext_pipe;
   import imm_ext_pkg::*;

`ifdef IMM_EXT_STATS_EN
   localparam int IN_W  = 8;
   localparam int OUT_W = 16;
`else
   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
`endif
   localparam int TAG_W = 4;

   logic             clk       = 1'b0;
   logic             reset     = 1'b1;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm    = '0;
   ext_mode_t        in_mode   = EXT_SIGN;
   logic [TAG_W-1:0] in_tag    = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
`ifdef IMM_EXT_STATS_EN
   logic [1:0]        stat_sel = 2'd0;
   logic [STAT_W-1:0] stat_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   imm_ext_pipe #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_imm     (in_imm),
      .in_mode    (in_mode),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag)
`ifdef IMM_EXT_STATS_EN
      ,
      .stat_sel   (stat_sel),
      .stat_count (stat_count)
`endif
   );

   task automatic push(input logic [IN_W-1:0] imm, input ext_mode_t mode, input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      n_cmp++; if (out_tag !== '0) begin n_bad++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      #5;
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
   endtask

`ifdef IMM_EXT_STATS_EN
   task automatic test_stats();
      logic [OUT_W-1:0] exp_d [5];
      logic [IN_W-1:0]  imm   [5];
      ext_mode_t        md    [5];
      logic [STAT_W-1:0] exp_c [4];
      imm   = '{8'h80, 8'h80, 8'h01, 8'h7F, 8'h81};
      md    = '{EXT_SIGN, EXT_UPPER, EXT_SIGN, EXT_SIGN, EXT_BRANCH};
      exp_d = '{16'hFF80, 16'h8000, 16'h0001, 16'h007F, 16'hFE04};
      exp_c = '{16'd3, 16'd0, 16'd1, 16'd1};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(imm[i], md[i], TAG_W'(i + 1));
         n_cmp++;
         if ({out_valid, out_tag, out_data} !== {1'b1, TAG_W'(i + 1), exp_d[i]}) begin
            n_bad++;
            $display("FAIL stats_ext[%0d]: got v=%b tag=%h data=%h expected v=1 tag=%h data=%h",
                     i, out_valid, out_tag, out_data, TAG_W'(i + 1), exp_d[i]);
         end
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
         stat_sel = 2'(s);
         #1;
         n_cmp++;
         if (stat_count !== exp_c[s]) begin
            n_bad++;
            $display("FAIL stat_count[%0d]: got %0d expected %0d", s, stat_count, exp_c[s]);
         end
      end
   endtask
`else
   task automatic test_sign();
      logic [IN_W-1:0]  imm   [4];
      logic [OUT_W-1:0] exp_d [4];
      imm   = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
      exp_d = '{32'h00007FFF, 32'hFFFF8000, 32'hFFFFFFFF, 32'h00000000};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(imm[i], EXT_SIGN, TAG_W'(i + 1));
         n_cmp++;
         if ({out_valid, out_tag, out_data} !== {1'b1, TAG_W'(i + 1), exp_d[i]}) begin
            n_bad++;
            $display("FAIL sign[%0d]: got v=%b tag=%h data=%h expected v=1 tag=%h data=%h",
                     i, out_valid, out_tag, out_data, TAG_W'(i + 1), exp_d[i]);
         end
      end
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sign_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_modes();
      logic [IN_W-1:0]  imm   [4];
      ext_mode_t        md    [4];
      logic [OUT_W-1:0] exp_d [4];
      imm   = '{16'h8001, 16'h8001, 16'h8001, 16'h1234};
      md    = '{EXT_ZERO, EXT_UPPER, EXT_BRANCH, EXT_BRANCH};
      exp_d = '{32'h00008001, 32'h80010000, 32'hFFFE0004, 32'h000048D0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(imm[i], md[i], TAG_W'(i + 8));
         n_cmp++;
         if ({out_valid, out_tag, out_data} !== {1'b1, TAG_W'(i + 8), exp_d[i]}) begin
            n_bad++;
            $display("FAIL mode[%0d]: got v=%b tag=%h data=%h expected v=1 tag=%h data=%h",
                     i, out_valid, out_tag, out_data, TAG_W'(i + 8), exp_d[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push(16'h1111, EXT_SIGN, 4'd1);
      push(16'h2222, EXT_SIGN, 4'd2);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
      n_cmp++;
      if ({out_valid, out_tag, out_data} !== {1'b1, 4'd1, 32'h00001111}) begin
         n_bad++;
         $display("FAIL bp_head: got v=%b tag=%h data=%h expected v=1 tag=1 data=00001111", out_valid, out_tag, out_data);
      end
      // A request offered while in_ready is low must wait.
      in_valid = 1'b1;
      in_imm   = 16'h3333;
      in_mode  = EXT_SIGN;
      in_tag   = 4'd3;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, out_tag, out_data} !== {1'b0, 4'd1, 32'h00001111}) begin
         n_bad++;
         $display("FAIL bp_hold: got rdy=%b tag=%h data=%h expected rdy=0 tag=1 data=00001111", in_ready, out_tag, out_data);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_tag, out_data} !== {1'b1, 4'd2, 32'h00002222}) begin
         n_bad++;
         $display("FAIL bp_second: got v=%b tag=%h data=%h expected v=1 tag=2 data=00002222", out_valid, out_tag, out_data);
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_high: got %b expected 1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, out_tag, out_data} !== {1'b1, 4'd3, 32'h00003333}) begin
         n_bad++;
         $display("FAIL bp_third: got v=%b tag=%h data=%h expected v=1 tag=3 data=00003333", out_valid, out_tag, out_data);
      end
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_streaming();
      logic [IN_W-1:0]  s_imm [8];
      logic [OUT_W-1:0] s_exp [8];
      int               sent;
      int               got;
      logic             stall;
      logic             acc;
      logic [OUT_W-1:0] hold_d;
      logic [TAG_W-1:0] hold_t;
      s_imm = '{16'h0001, 16'h8002, 16'h7FF3, 16'hFFF4, 16'h0105, 16'h8006, 16'h4007, 16'hC008};
      s_exp = '{32'h00000001, 32'hFFFF8002, 32'h00007FF3, 32'hFFFFFFF4,
                32'h00000105, 32'hFFFF8006, 32'h00004007, 32'hFFFFC008};
      sent  = 0;
      got   = 0;
      stall = 1'b0;
      hold_d = '0;
      hold_t = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         out_ready = cyc[0];
         in_valid  = (sent < 8);
         if (sent < 8) begin
            in_imm  = s_imm[sent];
            in_mode = EXT_SIGN;
            in_tag  = TAG_W'(sent);
         end
         if (stall) begin
            n_cmp++;
            if ({out_tag, out_data} !== {hold_t, hold_d}) begin
               n_bad++;
               $display("FAIL stream_stable: got tag=%h data=%h expected tag=%h data=%h", out_tag, out_data, hold_t, hold_d);
            end
         end
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            n_cmp++;
            if ({out_tag, out_data} !== {TAG_W'(got), s_exp[got]}) begin
               n_bad++;
               $display("FAIL stream[%0d]: got tag=%h data=%h expected tag=%h data=%h",
                        got, out_tag, out_data, TAG_W'(got), s_exp[got]);
            end
            got++;
         end
         stall  = out_valid && !out_ready;
         hold_d = out_data;
         hold_t = out_tag;
         @(posedge clk);
         #1;
         if (acc) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++; if (got != 8) begin n_bad++; $display("FAIL stream_count: got %0d expected 8", got); end
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_extra: got v=%b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      push(16'hAAAA, EXT_ZERO, 4'd6);
      push(16'h5555, EXT_ZERO, 4'd7);
      #3;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_tag, out_data, in_ready} !== {1'b0, 4'd0, 32'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL mid_reset: got v=%b tag=%h data=%h rdy=%b expected v=0 tag=0 data=0 rdy=0",
                  out_valid, out_tag, out_data, in_ready);
      end
      #10;
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b expected 1", in_ready); end
      out_ready = 1'b1;
      push(16'h00FF, EXT_SIGN, 4'd5);
      n_cmp++;
      if ({out_valid, out_tag, out_data} !== {1'b1, 4'd5, 32'h000000FF}) begin
         n_bad++;
         $display("FAIL mid_reset_next: got v=%b tag=%h data=%h expected v=1 tag=5 data=000000ff", out_valid, out_tag, out_data);
      end
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stale: got v=%b expected 0", out_valid); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef IMM_EXT_STATS_EN
      test_stats();
`else
      test_sign();
      test_modes();
      test_backpressure();
      test_streaming();
      test_reset_mid();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined successor of the combinational sign extender.
- Extends an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper-load and branch-offset.
- Registered output behind a valid/ready handshake, with a 2-entry skid buffer so upstream can stream one immediate per cycle without combinational ready paths.
- Sits between the decode stage and the ALU-source/branch-target muxes of the pipelined datapath.

Parameters:
- IN_W, 16, immediate input width; legal range 2..OUT_W-2.
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W+2 (elaboration-time assertion).
- TAG_W, 4, width of the opaque tag passed through alongside each immediate.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds an immediate.
- in_ready  out  1  block can accept; registered.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  extension mode (ext_mode_t).
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  out_data/out_tag valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag matching out_data.

Behaviour:
- Mode encoding:
  - 00 SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - 01 ZERO: upper bits are 0.
  - 10 UPPER: in_imm in bits [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - 11 BRANCH: sign-extend, then shift left 2; bits shifted past OUT_W-1 are dropped; bits [1:0] are 0.
- Extension is computed combinationally on the input side and captured into storage. Input values are not stored.
- Handshakes:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
- Storage:
  - Output register (OR) drives out_*.
  - Skid register (SK) holds one spill entry.
  - in_ready = !SK.valid, registered.
- Per-cycle rules:
  - Accept with OR empty, or OR draining this cycle with SK empty: result goes to OR.
  - Accept with OR full and not draining: result goes to SK, and in_ready drops next cycle.
  - OR drains with SK full: SK moves to OR, SK empties, and in_ready rises next cycle.
  - Accept and drain in the same cycle with SK empty: the new entry goes into OR. No bubble.
- Latency: 1 cycle from accept to out_valid when the pipe is empty. Throughput: 1 per cycle while out_ready=1.
- Ordering is strictly FIFO; out_tag always matches its data.
- out_data/out_tag must stay stable while out_valid && !out_ready. in_* are ignored when in_valid=0.
- Reset (asynchronous, including mid-transfer):
  - out_valid=0, out_data=0, out_tag=0.
  - SK cleared; in_ready=0 while reset is asserted, 1 on the first cycle after deassertion.
  - In-flight entries are discarded.
- Boundaries:
  - Both entries full and out_ready=0: hold indefinitely, in_ready=0.
  - in_valid while in_ready=0 is not accepted; upstream must hold.

Optional Feature:
- Macro: IMM_EXT_STATS_EN.
- When defined:
  - Adds input port stat_sel (2 bits) and output port stat_count (16 bits).
  - Four 16-bit saturating counters, one per mode, each increments on an accepted input of that mode and sticks at 0xFFFF.
  - stat_count = counter[stat_sel], combinational read.
  - Counters clear on reset.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package imm_ext_pkg:
  - typedef enum logic [1:0] ext_mode_t {EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH}.
  - Parametrised function ext_compute(imm, mode).
  - Constant STAT_W=16.
- Sub-module imm_ext_skid: generic 2-entry valid/ready skid buffer, parametrised on payload width (OUT_W+TAG_W).
- The top level holds the extension logic, the skid-buffer instance and the optional counters.

Test Plan:
- Default params, SIGN mode, out_ready=1: 0x7FFF -> 0x00007FFF; 0x8000 -> 0xFFFF8000; 0xFFFF -> 0xFFFFFFFF; 0x0000 -> 0x00000000. Each appears exactly 1 cycle after accept, with its tag.
- All modes on 0x8001: ZERO -> 0x00008001; UPPER -> 0x80010000; BRANCH -> 0xFFFE0004. On 0x1234: BRANCH -> 0x000048D0.
- Backpressure: out_ready=0 and send 0x1111 (tag 1), 0x2222 (tag 2) -> in_ready=0 after the second accept and out_data held at 0x00001111. Release out_ready -> 0x1111 then 0x2222 on consecutive cycles, then in_ready=1.
- Streaming: 8 back-to-back inputs with out_ready toggling every cycle -> no loss, no duplication, tags 0..7 in order, out_data stable while stalled.
- Reset asserted asynchronously with both entries full (mid-cycle, off clock edge) -> out_valid=0, out_data=0 immediately. After release, in_ready=1 and the next input 0x00FF SIGN -> 0x000000FF.
- IN_W=8, OUT_W=16, plus IMM_EXT_STATS_EN:
  - 0x80 SIGN -> 0xFF80; 0x80 UPPER -> 0x8000.
  - After 3 SIGN and 1 BRANCH accepts: stat_count = 3 with stat_sel=0, 1 with stat_sel=3.
